// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader.
// On start it pre-fills the whole memory with a two-byte fill pattern, then
// copies an incoming byte stream into memory from address 0, holds the CPU in
// reset for RESET_HOLD cycles after the final write, and finally releases it.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (running modulo-256 sum of
// accepted stream bytes; without it checksum is constant zero).
module prog_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [7:0]  FILL_EVEN  = 8'h00,
  parameter logic [7:0]  FILL_ODD   = 8'h00,
  parameter int          RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   bytes_loaded,
  output logic [7:0]            checksum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [7:0]            HOLD_LAST = 8'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Fill pattern byte for a given address (even/odd split).
  function automatic logic [7:0] fill_byte(input logic [ADDR_WIDTH-1:0] addr);
    return addr[0] ? FILL_ODD : FILL_EVEN;
  endfunction

  state_t                state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH:0]   bytes_q, bytes_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            hold_q, hold_d;
  logic                  in_ready_q, in_ready_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  handshake_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;

  // Next-state, write-port and counter logic; status outputs follow next state
  // so that the registered flags line up exactly with the state they describe.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    bytes_d     = bytes_q;
    ovf_d       = ovf_q;
    hold_d      = hold_q;
    handshake_s = in_valid & in_ready_q;
    next_addr_s = mem_addr_q + ADDR_ONE;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // First fill write is issued together with the entry into FILL.
          state_d     = ST_FILL;
          mem_we_d    = 1'b1;
          mem_addr_d  = {ADDR_WIDTH{1'b0}};
          mem_wdata_d = FILL_EVEN;
          bytes_d     = {(ADDR_WIDTH+1){1'b0}};
          ovf_d       = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_FILL: begin
        if (mem_addr_q == LAST_ADDR) begin
          state_d = ST_LOAD;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = next_addr_s;
          mem_wdata_d = fill_byte(next_addr_s);
        end
      end
      ST_LOAD: begin
        if (handshake_s) begin
          if (!bytes_q[ADDR_WIDTH]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = bytes_q[ADDR_WIDTH-1:0];
            mem_wdata_d = in_data;
            bytes_d     = bytes_q + CNT_ONE;
          end else begin
            ovf_d = 1'b1;
          end
          if (in_last) begin
            state_d = ST_RELEASE;
            hold_d  = 8'd0;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RELEASE: begin
        // RELEASE lasts RESET_HOLD cycles, the first carrying the trailing write.
        if (hold_q == HOLD_LAST) begin
          state_d = ST_DONE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_LOAD);
    cpu_reset_d = (state_d != ST_DONE);
    busy_d      = (state_d == ST_FILL) || (state_d == ST_LOAD) || (state_d == ST_RELEASE);
    done_d      = (state_d == ST_DONE);
  end

  // State and output registers; reset also cancels any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= 8'h00;
      bytes_q     <= {(ADDR_WIDTH+1){1'b0}};
      ovf_q       <= 1'b0;
      hold_q      <= 8'd0;
      in_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bytes_q     <= bytes_d;
      ovf_q       <= ovf_d;
      hold_q      <= hold_d;
      in_ready_q  <= in_ready_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  // Running sum of every accepted byte, including ones discarded on overflow.
  always_comb begin
    if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) begin
      checksum_d = 8'h00;
    end else if (handshake_s) begin
      checksum_d = checksum_q + in_data;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= 8'h00;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'h00;
`endif

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign bytes_loaded = bytes_q;

endmodule
